// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction_memory, and fills the IF/ID register.
// Handles stall, flush, branch redirect and halt-on-HALT_WORD, and counts valid fetches.
module instruction_fetch_unit #(
  parameter int unsigned              ADDR_W    = 64,
  parameter int unsigned              INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC  = '0,
  parameter int unsigned              PC_STEP   = 4,
  parameter logic [INSTR_W-1:0]       HALT_WORD = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               halted,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {START, RUN, HALT} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]    r_if_id_pc, w_if_id_pc_nxt;
  logic [INSTR_W-1:0]   r_if_id_instr, w_if_id_instr_nxt;
  logic                 r_if_id_valid, w_if_id_valid_nxt;
  logic                 r_halted, w_halted_nxt;
  logic                 r_misalign, w_misalign_nxt;
  logic [31:0]          r_fetch_count, w_fetch_count_nxt;

  logic [ADDR_W-1:0]    w_target_aligned;
  logic [ADDR_W-1:0]    w_pc_inc;
  logic                 w_target_misaligned;
  logic                 w_is_halt;

  assign w_target_aligned    = {branch_target[ADDR_W-1:2], 2'b00};
  assign w_target_misaligned = (branch_target[1:0] != 2'b00);
  assign w_pc_inc            = r_pc + ADDR_W'(PC_STEP);
  assign w_is_halt           = (Instruction == HALT_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= START;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      START:   w_state_nxt = RUN;
      RUN:     if (!branch_taken && !stall && !flush && w_is_halt) w_state_nxt = HALT;
      HALT:    if (branch_taken) w_state_nxt = RUN;
      default: w_state_nxt = START;
    endcase
  end

  always_comb begin
    w_pc_nxt          = r_pc;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_instr_nxt = r_if_id_instr;
    w_if_id_valid_nxt = r_if_id_valid;
    w_halted_nxt      = r_halted;
    w_misalign_nxt    = r_misalign;
    w_fetch_count_nxt = r_fetch_count;
    unique case (r_state)
      START: ;
      RUN: begin
        // Priority: redirect beats stall, stall beats flush, flush beats a normal fetch.
        if (branch_taken) begin
          w_pc_nxt          = w_target_aligned;
          w_if_id_valid_nxt = 1'b0;
          w_misalign_nxt    = r_misalign | w_target_misaligned;
        end else if (stall) begin
        end else if (flush) begin
          w_if_id_valid_nxt = 1'b0;
          w_pc_nxt          = w_pc_inc;
        end else begin
          w_if_id_instr_nxt = Instruction;
          w_if_id_pc_nxt    = r_pc;
          w_if_id_valid_nxt = 1'b1;
          w_fetch_count_nxt = r_fetch_count + 32'd1;
          if (w_is_halt) w_halted_nxt = 1'b1;
          else           w_pc_nxt     = w_pc_inc;
        end
      end
      HALT: begin
        w_if_id_valid_nxt = 1'b0;
        if (branch_taken) begin
          w_pc_nxt       = w_target_aligned;
          w_halted_nxt   = 1'b0;
          w_misalign_nxt = r_misalign | w_target_misaligned;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_instr <= w_if_id_instr_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_halted      <= w_halted_nxt;
      r_misalign    <= w_misalign_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign Address      = r_pc;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_instr  = r_if_id_instr;
  assign if_id_valid  = r_if_id_valid;
  assign halted       = r_halted;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stimulus queues hand-computed per-cycle
// expectations, and a negedge monitor pops and compares them against the outputs.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] Address;
  logic [31:0] Instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic        halt_en = 1'b0;

  instruction_fetch_unit #(
    .ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0), .PC_STEP(4), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .Address(Address), .Instruction(Instruction),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a is 0x1000_0000 + a, with an optional HALT_WORD at 0x10.
  always_comb begin
    if (halt_en && Address == 64'h10) Instruction = 32'hFFFF_FFFF;
    else                              Instruction = 32'h1000_0000 + Address[31:0];
  end

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [63:0] addr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(string nm, logic [63:0] a, logic [63:0] pc, logic [31:0] ins,
                              logic v, logic h, logic m, logic [31:0] c);
    exp_t e;
    e.cyc = 0; e.name = nm; e.addr = a; e.pc = pc; e.instr = ins;
    e.valid = v; e.halted = h; e.mis = m; e.cnt = c;
    return e;
  endfunction

  task automatic check(input exp_t e);
    n_vec++;
    if (Address !== e.addr || if_id_pc !== e.pc || if_id_instr !== e.instr ||
        if_id_valid !== e.valid || halted !== e.halted || misalign_err !== e.mis ||
        fetch_count !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: got addr=%h pc=%h instr=%h v=%b h=%b m=%b cnt=%0d, want addr=%h pc=%h instr=%h v=%b h=%b m=%b cnt=%0d",
               e.name, Address, if_id_pc, if_id_instr, if_id_valid, halted, misalign_err, fetch_count,
               e.addr, e.pc, e.instr, e.valid, e.halted, e.mis, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) check(sb.pop_front());
  end

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic step(input logic s, input logic f, input logic b, input logic [63:0] t, input exp_t e);
    stall = s; flush = f; branch_taken = b; branch_target = t;
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    e = mk("reset", 64'h0, 64'h0, 32'h0, 0, 0, 0, 0);
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk); #1;
    rst_n = 1'b1;

    step(0,0,0,64'h0,  mk("start_hold",   64'h0,  64'h0,  32'h0,         0,0,0,0));
    step(0,0,0,64'h0,  mk("fetch0",       64'h4,  64'h0,  32'h1000_0000, 1,0,0,1));
    step(0,0,0,64'h0,  mk("fetch4",       64'h8,  64'h4,  32'h1000_0004, 1,0,0,2));
    for (int i = 0; i < 3; i++)
      step(1,0,0,64'h0, mk("stall_hold",  64'h8,  64'h4,  32'h1000_0004, 1,0,0,2));
    step(0,0,0,64'h0,  mk("resume8",      64'hC,  64'h8,  32'h1000_0008, 1,0,0,3));
    step(1,0,1,64'h40, mk("br_over_stall",64'h40, 64'h8,  32'h1000_0008, 0,0,0,3));
    step(0,0,0,64'h0,  mk("fetch40",      64'h44, 64'h40, 32'h1000_0040, 1,0,0,4));
    step(0,1,0,64'h0,  mk("flush",        64'h48, 64'h40, 32'h1000_0040, 0,0,0,4));
    step(0,1,1,64'h43, mk("br_misalign",  64'h40, 64'h40, 32'h1000_0040, 0,0,1,4));
    step(0,0,0,64'h0,  mk("mis_sticky",   64'h44, 64'h40, 32'h1000_0040, 1,0,1,5));
    halt_en = 1'b1;
    step(0,0,1,64'h10, mk("br_to_10",     64'h10, 64'h40, 32'h1000_0040, 0,0,1,5));
    step(0,0,0,64'h0,  mk("halt_latch",   64'h10, 64'h10, 32'hFFFF_FFFF, 1,1,1,6));
    step(1,1,0,64'h0,  mk("halt_ign",     64'h10, 64'h10, 32'hFFFF_FFFF, 0,1,1,6));
    step(0,0,0,64'h0,  mk("halt_stay",    64'h10, 64'h10, 32'hFFFF_FFFF, 0,1,1,6));
    step(0,0,1,64'h0,  mk("halt_exit",    64'h0,  64'h10, 32'hFFFF_FFFF, 0,0,1,6));
    step(0,0,0,64'h0,  mk("restart0",     64'h4,  64'h0,  32'h1000_0000, 1,0,1,7));
    step(0,0,1,64'hFFFF_FFFF_FFFF_FFFC,
                       mk("br_top",       64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h1000_0000, 0,0,1,7));
    step(0,0,0,64'h0,  mk("pc_wrap",      64'h0,  64'hFFFF_FFFF_FFFF_FFFC, 32'h0FFF_FFFC, 1,0,1,8));
    step(0,0,0,64'h0,  mk("after_wrap",   64'h4,  64'h0,  32'h1000_0000, 1,0,1,9));

    // Let the monitor drain, then pulse reset between edges and check it took effect at once.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check(mk("async_reset", 64'h0, 64'h0, 32'h0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0,0,0,64'h0,  mk("re_start",     64'h0,  64'h0,  32'h0,         0,0,0,0));
    step(0,0,0,64'h0,  mk("re_fetch0",    64'h4,  64'h0,  32'h1000_0000, 1,0,0,1));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: expectation never compared, still queued at cycle %0d", e.name, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage sitting directly upstream of instruction_memory.
- Owns the program counter and drives the 64-bit Address into the combinational instruction_memory.
- Captures the returned 32-bit Instruction into the IF/ID pipeline register.
- Handles stall, branch redirect, flush and halt detection, and counts retired fetches.

Parameters:
- ADDR_W, 64, PC / address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  squash IF/ID contents; PC keeps advancing.
- branch_taken  in  1  redirect PC to branch_target.
- branch_target  in  ADDR_W  redirect address.
- Address  out  ADDR_W  to instruction_memory; always equals the internal PC register.
- Instruction  in  INSTR_W  from instruction_memory, combinational on Address.
- if_id_pc  out  ADDR_W  PC of the latched instruction.
- if_id_instr  out  INSTR_W  latched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on HALT_WORD.
- misalign_err  out  1  sticky; a branch_target had bits [1:0] != 0.
- fetch_count  out  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (async, rst_n=0) sets:
  - PC=RESET_PC, if_id_pc=0, if_id_instr=0, if_id_valid=0.
  - halted=0, misalign_err=0, fetch_count=0, state=START.
- Reset asserted mid-operation overrides everything immediately.
- States:
  - START: one cycle after reset release. Address=RESET_PC, if_id_valid stays 0, PC unchanged. Always goes to RUN.
  - RUN: normal fetch.
  - HALT: PC frozen, if_id_valid=0.
- RUN per rising edge, in priority order:
  1. branch_taken: PC<=target with [1:0] forced to 0; if_id_valid<=0; wrong-path instruction discarded. Applies even if stall=1. Set misalign_err if target[1:0]!=0.
  2. stall: PC, if_id_*, fetch_count all hold.
  3. flush: if_id_valid<=0; PC<=PC+PC_STEP; fetch_count unchanged.
  4. Otherwise:
     - if_id_instr<=Instruction, if_id_pc<=PC, if_id_valid<=1, fetch_count+=1, PC<=PC+PC_STEP.
     - If Instruction==HALT_WORD: the instruction is still latched valid, PC holds (no increment), and next state is HALT with halted<=1.
- HALT:
  - First cycle clears if_id_valid.
  - Stays in HALT until branch_taken. Then PC<=target, halted<=0, state RUN; the next edge fetches normally.
  - stall and flush are ignored in HALT.
- Latency: instruction at PC appears on if_id_* one edge after Address=PC is presented without stall.
- Arithmetic:
  - PC+PC_STEP is modulo 2^ADDR_W; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no error.
  - fetch_count wraps modulo 2^32.
- misalign_err clears only on reset.
- Simultaneous events:
  - branch_taken + flush behaves as branch only.
  - branch_taken + stall: the redirect wins.

Test Plan:
- Reset release, memory holding sequential words, no stall → Address 0,0,4,8,...; START holds 0 for the extra cycle; if_id_pc 0,4,8 with matching instr; if_id_valid rises on the 2nd edge after release; fetch_count=3 after 3 fetches.
- stall=1 for 3 cycles at PC=8 → Address stays 8; if_id_pc stays 4; fetch_count unchanged; resumes with if_id_pc=8.
- branch_taken with target 0x40 while stall=1 → next Address=0x40; if_id_valid=0; following edge gives if_id_pc=0x40.
- branch_target=0x43 → PC=0x40; misalign_err=1 and stays 1 through later fetches until rst_n=0.
- HALT_WORD stored at 0x10 → latched valid with if_id_pc=0x10; then halted=1, Address frozen at 0x10, if_id_valid=0; branch to 0x0 clears halted and fetch restarts at 0.
- PC forced via branch to 64'hFFFF_FFFF_FFFF_FFFC → next Address=0. Separately, rst_n pulsed low mid-stream → all outputs zero asynchronously, before the next clock edge.
